// File: rtl/mv_mac_sequencer_pkg.sv
// Shared types and constants for the time-multiplexed 3x3 matrix x 3-vector MAC sequencer.
package mv_mac_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 2 * DEF_DATA_W + 2;

   localparam logic [3:0] A11    = 4'd0;
   localparam logic [3:0] A12    = 4'd1;
   localparam logic [3:0] A13    = 4'd2;
   localparam logic [3:0] A21    = 4'd3;
   localparam logic [3:0] A22    = 4'd4;
   localparam logic [3:0] A23    = 4'd5;
   localparam logic [3:0] A31    = 4'd6;
   localparam logic [3:0] A32    = 4'd7;
   localparam logic [3:0] A33    = 4'd8;
   localparam logic [3:0] N_ELEM = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [1:0] elem_row(input logic [3:0] idx);
      case (idx)
         A11, A12, A13: return 2'd0;
         A21, A22, A23: return 2'd1;
         A31, A32, A33: return 2'd2;
         default:       return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] elem_col(input logic [3:0] idx);
      case (idx)
         A11, A21, A31: return 2'd0;
         A12, A22, A32: return 2'd1;
         A13, A23, A33: return 2'd2;
         default:       return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mv_mac_sequencer_if.sv
// Configuration, vector-input and result handshakes of the matrix-vector MAC sequencer.
interface mv_mac_sequencer_if #(
   parameter int DATA_W = mv_mac_pkg::DEF_DATA_W,
   parameter int ACC_W  = mv_mac_pkg::DEF_ACC_W
);
   logic              cfg_we;
   logic [3:0]        cfg_addr;
   logic [DATA_W-1:0] cfg_wdata;
   logic              cfg_err;
   logic              vec_valid;
   logic              vec_ready;
   logic [DATA_W-1:0] b1, b2, b3;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  c1, c2, c3;
   logic              busy;

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, vec_valid, b1, b2, b3, out_ready,
      output cfg_err, vec_ready, out_valid, c1, c2, c3, busy
   );

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, vec_valid, b1, b2, b3, out_ready,
      input  cfg_err, vec_ready, out_valid, c1, c2, c3, busy
   );
endinterface

// File: rtl/mv_mac_sequencer_mac_unit.sv
// Single shared multiply-accumulate stage: acc_out is the running sum including this product,
// which the accumulator register takes on each enabled step.
module mac_unit #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 2 * DATA_W + 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic              clear_en,
   input  logic [DATA_W-1:0] a_op,
   input  logic [DATA_W-1:0] b_op,
   output logic [ACC_W-1:0]  acc_out
);
   logic [ACC_W-1:0]    acc_r;
   logic [ACC_W-1:0]    base_s;
   logic [2*DATA_W-1:0] prod_s;

   // Product added to the running sum, or to zero at the first column of a row.
   always_comb begin
      prod_s = {{DATA_W{1'b0}}, a_op} * {{DATA_W{1'b0}}, b_op};
      if (clear_en) begin
         base_s = {ACC_W{1'b0}};
      end else begin
         base_s = acc_r;
      end
      acc_out = base_s + {{(ACC_W - 2 * DATA_W){1'b0}}, prod_s};
   end

   // Accumulator register: cleared at job start, advanced once per MAC step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (clr) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (en) begin
         acc_r <= acc_out;
      end
   end
endmodule

// File: rtl/mv_mac_sequencer.sv
// 3x3 matrix x 3-vector engine: matrix regfile, FSM and index counter feed one shared
// 8x8 multiplier-accumulator, one element product per cycle.
module mv_mac_sequencer import mv_mac_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = 2 * DATA_W + 2
) (
   input logic               clk,
   input logic               reset,
   mv_mac_sequencer_if.slave bus
);
   state_t            state_r, state_nxt_s;
   logic [3:0]        idx_r;
   logic [DATA_W-1:0] a_r [0:8];
   logic [DATA_W-1:0] b_r [0:2];
   logic [ACC_W-1:0]  c_r [0:2];
   logic              out_valid_r, cfg_err_r;
   logic              accept_s, mac_s, last_s, row_end_s, cfg_ok_s, clear_en_s;
   logic [1:0]        row_s, col_s;
   logic [DATA_W-1:0] a_op_s, b_op_s;
   logic [ACC_W-1:0]  acc_s;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    if (bus.vec_valid)  state_nxt_s = MAC;  else state_nxt_s = IDLE;
         MAC:     if (idx_r == A33)   state_nxt_s = DONE; else state_nxt_s = MAC;
         DONE:    if (bus.out_ready)  state_nxt_s = IDLE; else state_nxt_s = DONE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Control decode and operand selection for the current element index.
   always_comb begin
      accept_s = 1'b0;
      mac_s    = 1'b0;
      last_s   = 1'b0;
      case (state_r)
         IDLE:    accept_s = bus.vec_valid;
         MAC: begin
            mac_s  = 1'b1;
            last_s = (idx_r == A33);
         end
         DONE:    accept_s = 1'b0;
         default: accept_s = 1'b0;
      endcase
      row_s      = elem_row(idx_r);
      col_s      = elem_col(idx_r);
      a_op_s     = a_r[idx_r];
      b_op_s     = b_r[col_s];
      clear_en_s = (col_s == 2'd0);
      row_end_s  = mac_s && (col_s == 2'd2);
      cfg_ok_s   = bus.cfg_we && (state_r == IDLE) && (bus.cfg_addr < N_ELEM);
   end

   // Job datapath: vector capture at accept, index stepping, row results, result valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_r       <= A11;
         out_valid_r <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            b_r[i] <= {DATA_W{1'b0}};
            c_r[i] <= {ACC_W{1'b0}};
         end
      end else begin
         if (accept_s) begin
            idx_r  <= A11;
            b_r[0] <= bus.b1;
            b_r[1] <= bus.b2;
            b_r[2] <= bus.b3;
         end else if (mac_s && !last_s) begin
            idx_r <= idx_r + 4'd1;
         end
         if (row_end_s) begin
            c_r[row_s] <= acc_s;
         end
         if (last_s) begin
            out_valid_r <= 1'b1;
         end else if ((state_r == DONE) && bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   // Matrix register file; rejected writes raise a one-cycle error pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_err_r <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            a_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         if (cfg_ok_s) begin
            a_r[bus.cfg_addr] <= bus.cfg_wdata;
         end
         cfg_err_r <= bus.cfg_we && !cfg_ok_s;
      end
   end

   mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .clk      (clk),
      .reset    (reset),
      .clr      (accept_s),
      .en       (mac_s),
      .clear_en (clear_en_s),
      .a_op     (a_op_s),
      .b_op     (b_op_s),
      .acc_out  (acc_s)
   );

   assign bus.vec_ready = (state_r == IDLE);
   assign bus.busy      = (state_r != IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.cfg_err   = cfg_err_r;
   assign bus.c1        = c_r[0];
   assign bus.c2        = c_r[1];
   assign bus.c3        = c_r[2];
endmodule

// File: tb/tb_mv_mac_sequencer.sv
// Self-checking bench for mv_mac_sequencer: directed and random jobs against a plain
// arithmetic matrix-vector reference.
module tb_mv_mac_sequencer;
   localparam int DW = 8;
   localparam int AW = 18;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mv_mac_sequencer_if #(.DATA_W(DW), .ACC_W(AW)) bus ();
   mv_mac_sequencer #(.DATA_W(DW), .ACC_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

   int vectors     = 0;
   int miscompares = 0;
   int am [9];

   function automatic logic [AW-1:0] model_c(input int r, input int v0, input int v1, input int v2);
      int s;
      s = am[3*r] * v0 + am[3*r+1] * v1 + am[3*r+2] * v2;
      return AW'(s);
   endfunction

   task automatic cfg_write(input int addr, input int data, output logic err);
      bus.cfg_we = 1'b1; bus.cfg_addr = 4'(addr); bus.cfg_wdata = 8'(data);
      @(negedge clk);
      bus.cfg_we = 1'b0;
      err = bus.cfg_err;
   endtask

   task automatic load_matrix();
      logic e;
      for (int i = 0; i < 9; i++) begin
         cfg_write(i, am[i], e);
         vectors++;
         if (e !== 1'b0) begin miscompares++; $display("FAIL cfg_load_err addr %0d: got %b want 0", i, e); end
      end
   endtask

   task automatic wait_valid(inout int lat);
      while (bus.out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic run_job(input int v0, input int v1, input int v2, output int lat);
      bus.b1 = 8'(v0); bus.b2 = 8'(v1); bus.b3 = 8'(v2); bus.vec_valid = 1'b1;
      @(negedge clk);
      bus.vec_valid = 1'b0;
      bus.b1 = 8'($urandom); bus.b2 = 8'($urandom); bus.b3 = 8'($urandom);
      lat = 0;
      wait_valid(lat);
   endtask

   task automatic take_result();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic check_job(input string nm, input int lat, input int v0, input int v1, input int v2);
      logic [AW-1:0] got [3];
      got[0] = bus.c1; got[1] = bus.c2; got[2] = bus.c3;
      vectors++;
      if (lat != 9) begin miscompares++; $display("FAIL %s latency: got %0d want 9", nm, lat); end
      for (int r = 0; r < 3; r++) begin
         vectors++;
         if (got[r] !== model_c(r, v0, v1, v2)) begin
            miscompares++; $display("FAIL %s c%0d: got %0d want %0d", nm, r + 1, got[r], model_c(r, v0, v1, v2));
         end
      end
   endtask

   task automatic test_reset();
      vectors++;
      if ({bus.vec_ready, bus.busy, bus.out_valid, bus.cfg_err} !== 4'b1000) begin
         miscompares++; $display("FAIL reset_ctl: got %b want 1000", {bus.vec_ready, bus.busy, bus.out_valid, bus.cfg_err});
      end
      vectors++;
      if ({bus.c1, bus.c2, bus.c3} !== {(3*AW){1'b0}}) begin
         miscompares++; $display("FAIL reset_c: got %0d %0d %0d want 0 0 0", bus.c1, bus.c2, bus.c3);
      end
   endtask

   task automatic test_identity();
      int lat;
      for (int i = 0; i < 9; i++) am[i] = (i % 4 == 0) ? 1 : 0;
      load_matrix();
      run_job(1, 2, 3, lat);
      check_job("identity", lat, 1, 2, 3);
      take_result();
      vectors++;
      if ({bus.out_valid, bus.vec_ready} !== 2'b01) begin
         miscompares++; $display("FAIL identity_done: got %b want 01", {bus.out_valid, bus.vec_ready});
      end
   endtask

   task automatic test_max();
      int lat;
      for (int i = 0; i < 9; i++) am[i] = 255;
      load_matrix();
      run_job(255, 255, 255, lat);
      check_job("max", lat, 255, 255, 255);
      take_result();
   endtask

   task automatic test_stall();
      int lat;
      logic [AW-1:0] ec [3];
      for (int i = 0; i < 9; i++) am[i] = i + 1;
      load_matrix();
      run_job(1, 0, 2, lat);
      check_job("stall", lat, 1, 0, 2);
      for (int r = 0; r < 3; r++) ec[r] = model_c(r, 1, 0, 2);
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if ({bus.out_valid, bus.vec_ready, bus.busy} !== 3'b101) begin
            miscompares++; $display("FAIL stall_hs cycle %0d: got %b want 101", k, {bus.out_valid, bus.vec_ready, bus.busy});
         end
         vectors++;
         if ({bus.c1, bus.c2, bus.c3} !== {ec[0], ec[1], ec[2]}) begin
            miscompares++; $display("FAIL stall_hold cycle %0d: got %0d %0d %0d want %0d %0d %0d", k, bus.c1, bus.c2, bus.c3, ec[0], ec[1], ec[2]);
         end
         @(negedge clk);
      end
      take_result();
      vectors++;
      if ({bus.out_valid, bus.vec_ready, bus.busy} !== 3'b010 || bus.c1 !== ec[0]) begin
         miscompares++; $display("FAIL stall_release: got %b c1=%0d want 010 c1=%0d", {bus.out_valid, bus.vec_ready, bus.busy}, bus.c1, ec[0]);
      end
   endtask

   task automatic test_cfg_err();
      int lat, v0, v1, v2;
      logic e;
      v0 = $urandom_range(0, 255); v1 = $urandom_range(0, 255); v2 = $urandom_range(0, 255);
      bus.b1 = 8'(v0); bus.b2 = 8'(v1); bus.b3 = 8'(v2); bus.vec_valid = 1'b1;
      @(negedge clk);
      bus.vec_valid = 1'b0;
      cfg_write(4, 99, e);
      vectors++;
      if (e !== 1'b1) begin miscompares++; $display("FAIL cfg_busy_err: got %b want 1", e); end
      @(negedge clk);
      vectors++;
      if (bus.cfg_err !== 1'b0) begin miscompares++; $display("FAIL cfg_err_pulse: got %b want 0", bus.cfg_err); end
      lat = 2;
      wait_valid(lat);
      check_job("cfg_busy", lat, v0, v1, v2);
      take_result();
      cfg_write(12, 77, e);
      vectors++;
      if (e !== 1'b1) begin miscompares++; $display("FAIL cfg_addr_err: got %b want 1", e); end
      cfg_write(4, 99, e);
      am[4] = 99;
      vectors++;
      if (e !== 1'b0) begin miscompares++; $display("FAIL cfg_idle_ok: got %b want 0", e); end
      bus.cfg_we = 1'b1; bus.cfg_addr = 4'd0; bus.cfg_wdata = 8'd50;
      bus.b1 = 8'(v0); bus.b2 = 8'(v1); bus.b3 = 8'(v2); bus.vec_valid = 1'b1;
      am[0] = 50;
      @(negedge clk);
      bus.cfg_we = 1'b0; bus.vec_valid = 1'b0;
      lat = 0;
      wait_valid(lat);
      check_job("cfg_same_cycle", lat, v0, v1, v2);
      take_result();
   endtask

   task automatic test_reset_mid_job();
      int lat, v0, v1, v2;
      for (int i = 0; i < 9; i++) am[i] = $urandom_range(1, 255);
      load_matrix();
      bus.b1 = 8'd200; bus.b2 = 8'd150; bus.b3 = 8'd100; bus.vec_valid = 1'b1;
      @(negedge clk);
      bus.vec_valid = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.out_valid, bus.busy, bus.vec_ready} !== 3'b001 || {bus.c1, bus.c2, bus.c3} !== {(3*AW){1'b0}}) begin
         miscompares++; $display("FAIL midjob_reset: got ctl %b c %0d %0d %0d want 001 c 0 0 0", {bus.out_valid, bus.busy, bus.vec_ready}, bus.c1, bus.c2, bus.c3);
      end
      reset = 1'b0;
      for (int i = 0; i < 9; i++) am[i] = 0;
      v0 = $urandom_range(1, 255); v1 = $urandom_range(1, 255); v2 = $urandom_range(1, 255);
      run_job(v0, v1, v2, lat);
      check_job("after_reset", lat, v0, v1, v2);
      take_result();
   endtask

   task automatic test_random();
      int lat, v0, v1, v2;
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 9; i++) am[i] = $urandom_range(0, 255);
         load_matrix();
         v0 = $urandom_range(0, 255); v1 = $urandom_range(0, 255); v2 = $urandom_range(0, 255);
         run_job(v0, v1, v2, lat);
         check_job("random", lat, v0, v1, v2);
         take_result();
      end
   endtask

   task automatic test_back_to_back();
      int vb [4][3];
      logic [AW-1:0] ex [4][3];
      int sent, got, cyc, last_acc;
      for (int i = 0; i < 9; i++) am[i] = $urandom_range(0, 255);
      load_matrix();
      for (int j = 0; j < 4; j++) begin
         for (int k = 0; k < 3; k++) vb[j][k] = $urandom_range(0, 255);
         for (int r = 0; r < 3; r++) ex[j][r] = model_c(r, vb[j][0], vb[j][1], vb[j][2]);
      end
      sent = 0; got = 0; cyc = 0; last_acc = 0;
      bus.out_ready = 1'b1;
      while (got < 4 && cyc < 200) begin
         if (sent < 4) begin
            bus.b1 = 8'(vb[sent][0]); bus.b2 = 8'(vb[sent][1]); bus.b3 = 8'(vb[sent][2]);
            bus.vec_valid = 1'b1;
         end else begin
            bus.vec_valid = 1'b0;
         end
         if (bus.out_valid === 1'b1) begin
            vectors++;
            if ({bus.c1, bus.c2, bus.c3} !== {ex[got][0], ex[got][1], ex[got][2]}) begin
               miscompares++; $display("FAIL b2b_result %0d: got %0d %0d %0d want %0d %0d %0d", got, bus.c1, bus.c2, bus.c3, ex[got][0], ex[got][1], ex[got][2]);
            end
            got++;
         end
         if (bus.vec_ready === 1'b1 && bus.vec_valid === 1'b1) begin
            if (sent > 0) begin
               vectors++;
               if (cyc - last_acc != 11) begin
                  miscompares++; $display("FAIL b2b_spacing %0d: got %0d want 11", sent, cyc - last_acc);
               end
            end
            last_acc = cyc;
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (got != 4) begin miscompares++; $display("FAIL b2b_timeout: got %0d results want 4", got); end
      bus.out_ready = 1'b0; bus.vec_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      bus.cfg_we = 1'b0; bus.cfg_addr = 4'd0; bus.cfg_wdata = 8'd0;
      bus.vec_valid = 1'b0; bus.b1 = 8'd0; bus.b2 = 8'd0; bus.b3 = 8'd0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_identity();
      test_max();
      test_stall();
      test_cfg_err();
      test_reset_mid_job();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
